// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the parametrised LFSR generator.
package lfsr_pkg;

  // Run-time feedback structure selection.
  localparam logic MODE_GALOIS = 1'b0;
  localparam logic MODE_FIB    = 1'b1;

  // Value with the low 'width' bits set; used as the default seed.
  function automatic logic [31:0] seed_all_ones(input int unsigned width);
    if (width >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Next-state function of the LFSR for both Galois and Fibonacci structures.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] GAL_POLY = WIDTH'(4'b0011),
  parameter logic [WIDTH-1:0] FIB_TAPS = WIDTH'(4'b1100)
) (
  input  logic [WIDTH-1:0] q,
  input  logic             mode,
  output logic [WIDTH-1:0] nq
);

  logic             gal_fb;
  logic             fib_fb;
  logic [WIDTH-1:0] gal_nq;
  logic [WIDTH-1:0] fib_nq;

  // Compute both candidate next states and pick one by mode.
  always_comb begin
    // Galois: shift left, the outgoing MSB re-enters at bit 0 and is XORed
    // into every position whose polynomial coefficient is set (bit 0 is the
    // re-entry itself, so its coefficient is not used again).
    gal_fb = q[WIDTH-1];
    gal_nq = {q[WIDTH-2:0], gal_fb} ^ ({GAL_POLY[WIDTH-1:1], 1'b0} & {WIDTH{gal_fb}});
    // Fibonacci: parity of the tapped bits is shifted in at bit 0.
    fib_fb = ^(q & FIB_TAPS);
    fib_nq = {q[WIDTH-2:0], fib_fb};
    nq     = (mode == MODE_FIB) ? fib_nq : gal_nq;
  end

endmodule

// File: rtl/lfsr_param.sv
// Parametrised LFSR with seed load, step enable, all-zero load protection
// and measurement of the number of steps until the start state recurs.
module lfsr_param
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] GAL_POLY = WIDTH'(4'b0011),
  parameter logic [WIDTH-1:0] FIB_TAPS = WIDTH'(4'b1100),
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(seed_all_ones(WIDTH))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             bit_out,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             period_vld,
  output logic             zero_fix
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             period_vld_q, period_vld_d;
  logic             wrap_q, wrap_d;
  logic             zero_fix_q, zero_fix_d;
  logic [WIDTH-1:0] nq;

  lfsr_next #(
    .WIDTH    (WIDTH),
    .GAL_POLY (GAL_POLY),
    .FIB_TAPS (FIB_TAPS)
  ) u_next (
    .q    (q_q),
    .mode (mode),
    .nq   (nq)
  );

  // Next-state decision: load beats step, step beats hold.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    q_d          = q_q;
    start_d      = start_q;
    step_cnt_d   = step_cnt_q;
    period_d     = period_q;
    period_vld_d = period_vld_q;
    wrap_d       = 1'b0;
    zero_fix_d   = 1'b0;

    if (load) begin
      // An all-zero state would lock up, so it is replaced by the seed.
      if (seed_in == '0) begin
        q_d        = SEED;
        start_d    = SEED;
        zero_fix_d = 1'b1;
      end else begin
        q_d     = seed_in;
        start_d = seed_in;
      end
      step_cnt_d   = '0;
      period_vld_d = 1'b0;
    end else if (en) begin
      q_d = nq;
      if (nq == start_q) begin
        wrap_d       = 1'b1;
        period_d     = step_cnt_q + ONE;
        period_vld_d = 1'b1;
        step_cnt_d   = '0;
      end else if (step_cnt_q != '1) begin
        // Saturate so a start state that never recurs cannot fake a period.
        step_cnt_d = step_cnt_q + ONE;
      end
    end
  end

  // State and flag registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q          <= SEED;
      start_q      <= SEED;
      step_cnt_q   <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      wrap_q       <= 1'b0;
      zero_fix_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      q_q          <= q_d;
      start_q      <= start_d;
      step_cnt_q   <= step_cnt_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      wrap_q       <= wrap_d;
      zero_fix_q   <= zero_fix_d;
    end
  end

  assign q          = q_q;
  assign bit_out    = q_q[WIDTH-1];
  assign wrap       = wrap_q;
  assign period     = period_q;
  assign period_vld = period_vld_q;
  assign zero_fix   = zero_fix_q;

endmodule

// File: tb/tb_lfsr_param.sv
// Self-checking bench for lfsr_param (WIDTH=4, default taps): directed
// sequences with literal expectations plus randomized traffic compared every
// cycle against a polynomial-arithmetic reference model.
module tb_lfsr_param;

  localparam int         W    = 4;
  localparam int         MASK = (1 << W) - 1;
  localparam logic [3:0] GP   = 4'b0011;
  localparam logic [3:0] FT   = 4'b1100;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] seed_in;
  logic       mode;
  logic [3:0] q;
  logic       bit_out;
  logic       wrap;
  logic [3:0] period;
  logic       period_vld;
  logic       zero_fix;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 0;

  // Reference model state (plain integers).
  int m_q, m_start, m_cnt, m_period;
  bit m_vld, m_wrap, m_zfix;

  lfsr_param dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .seed_in    (seed_in),
    .mode       (mode),
    .q          (q),
    .bit_out    (bit_out),
    .wrap       (wrap),
    .period     (period),
    .period_vld (period_vld),
    .zero_fix   (zero_fix)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Galois step = multiply by x modulo P(x) = x^W + GP; Fibonacci step =
  // shift in the parity of the tapped bits.
  function automatic int model_next(input int s, input bit m);
    int t;
    if (m == 1'b0) begin
      t = s << 1;
      if ((t & (1 << W)) != 0) t = t ^ ((1 << W) | int'(GP));
      return t;
    end
    return ((s << 1) & MASK) | ($countones(s & int'(FT)) & 1);
  endfunction

  // Reference model: advances on the same edges as the DUT.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q = MASK; m_start = MASK; m_cnt = 0; m_period = 0;
      m_vld = 0; m_wrap = 0; m_zfix = 0;
    end else begin
      m_wrap = 0;
      m_zfix = 0;
      if (load) begin
        if (seed_in == 0) begin
          m_q = MASK;
          m_zfix = 1;
        end else begin
          m_q = int'(seed_in);
        end
        m_start = m_q;
        m_cnt = 0;
        m_vld = 0;
      end else if (en) begin
        m_q = model_next(m_q, mode);
        if (m_q == m_start) begin
          m_wrap = 1;
          m_period = (m_cnt + 1) & MASK;
          m_vld = 1;
          m_cnt = 0;
        end else if (m_cnt < MASK) begin
          m_cnt++;
        end
      end
    end
  end

  // Compare process: all outputs against the model every cycle out of reset.
  always @(negedge clk) begin
    if (rst && chk_on) begin
      check("cyc_q", 32'(q), 32'(m_q));
      check("cyc_bit_out", 32'(bit_out), 32'((m_q >> (W - 1)) & 1));
      check("cyc_wrap", 32'(wrap), 32'(m_wrap));
      check("cyc_period", 32'(period), 32'(m_period));
      check("cyc_period_vld", 32'(period_vld), 32'(m_vld));
      check("cyc_zero_fix", 32'(zero_fix), 32'(m_zfix));
    end
  end

  task automatic step(input logic l, input logic e, input logic [3:0] s, input logic m);
    load = l; en = e; seed_in = s; mode = m;
    @(posedge clk);
    #1;
  endtask

  // Step until wrap is seen, bounded; returns the number of cycles used.
  task automatic run_to_wrap(input logic m, input bit toggle, input int bound, output int n);
    n = 0;
    for (int i = 0; i < bound; i++) begin
      step(1'b0, toggle ? logic'(i % 2) : 1'b1, 4'd0, m);
      n++;
      if (wrap) break;
    end
  endtask

  logic [3:0] gal_seq [7];
  logic [3:0] fib_seq [7];
  int n;
  logic [3:0] rs;

  initial begin
    gal_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0110, 4'b1100, 4'b1011};
    fib_seq = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010};
    rst = 1'b1; en = 1'b0; load = 1'b0; seed_in = 4'd0; mode = 1'b0;
    #1 rst = 1'b0;
    #4;
    check("rst_q", 32'(q), 32'hF);
    check("rst_period", 32'(period), 32'h0);
    check("rst_period_vld", 32'(period_vld), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_zero_fix", 32'(zero_fix), 32'h0);
    #20 rst = 1'b1;   // release at 25 ns
    chk_on = 1;

    // 1. Galois from 0001.
    step(1'b1, 1'b0, 4'b0001, 1'b0);
    check("gal_load_q", 32'(q), 32'h1);
    for (int i = 1; i <= 15; i++) begin
      step(1'b0, 1'b1, 4'd0, 1'b0);
      if (i <= 7) check("gal_seq", 32'(q), 32'(gal_seq[i-1]));
      if (i == 14) check("gal_no_early_wrap", 32'(wrap), 32'h0);
    end
    check("gal_wrap_q", 32'(q), 32'h1);
    check("gal_wrap", 32'(wrap), 32'h1);
    check("gal_period", 32'(period), 32'd15);
    check("gal_period_vld", 32'(period_vld), 32'h1);

    // 2. Fibonacci from 0001.
    step(1'b1, 1'b1, 4'b0001, 1'b1);
    check("fib_load_vld_clr", 32'(period_vld), 32'h0);
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 1'b1, 4'd0, 1'b1);
      check("fib_seq", 32'(q), 32'(fib_seq[i-1]));
    end
    run_to_wrap(1'b1, 1'b0, 40, n);
    check("fib_steps_to_wrap", 32'(n + 7), 32'd15);
    check("fib_period", 32'(period), 32'd15);

    // 3. All-zero load replaced by the seed.
    step(1'b1, 1'b0, 4'd0, 1'b0);
    check("zero_q", 32'(q), 32'hF);
    check("zero_fix_pulse", 32'(zero_fix), 32'h1);
    check("zero_period_vld", 32'(period_vld), 32'h0);
    step(1'b0, 1'b0, 4'd0, 1'b0);
    check("zero_fix_drop", 32'(zero_fix), 32'h0);

    // 4. load wins over en; counter restarts from zero.
    step(1'b1, 1'b1, 4'b0101, 1'b0);
    check("load_en_q", 32'(q), 32'b0101);
    run_to_wrap(1'b0, 1'b0, 40, n);
    check("load_en_steps", 32'(n), 32'd15);
    check("load_en_period", 32'(period), 32'd15);

    // 5. en toggling: 15 steps spread over 30 cycles.
    step(1'b1, 1'b0, 4'b0001, 1'b0);
    run_to_wrap(1'b0, 1'b1, 100, n);
    check("toggle_cycles", 32'(n), 32'd30);
    check("toggle_period", 32'(period), 32'd15);

    // 6. Asynchronous reset between edges.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'd0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_q", 32'(q), 32'hF);
    check("mid_rst_vld", 32'(period_vld), 32'h0);
    @(posedge clk);
    #3 rst = 1'b1;
    step(1'b0, 1'b1, 4'd0, 1'b0);
    check("post_rst_first", 32'(q), 32'b1101);
    run_to_wrap(1'b0, 1'b0, 40, n);
    check("post_rst_steps", 32'(n + 1), 32'd15);
    check("post_rst_period", 32'(period), 32'd15);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      step(logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 9) < 6),
           rs, logic'($urandom_range(0, 15) == 0 ? ~mode : mode));
    end

    step(1'b0, 1'b0, 4'd0, mode);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
